// File: rtl/cache_control_pkg.sv
// Shared LC-3b types used by the L1 cache controller and its tag store.
package lc3b_types;

    localparam int TAG_WIDTH = 9;
    localparam int NUM_SETS  = 8;

    typedef logic [15:0]          lc3b_word;
    typedef logic [2:0]           lc3b_3bit;
    typedef logic [TAG_WIDTH-1:0] lc3b_tag;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } lc3b_cache_state;

endpackage

// File: rtl/cache_control_tag_array.sv
// Per-set valid/dirty/tag store for the direct-mapped L1, with combinational
// lookup of the addressed set and a hit compare against the incoming tag.
module cache_tag_array
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  lc3b_3bit set,
    input  lc3b_tag  tag_in,
    input  logic     load_tag,
    input  logic     set_dirty,
    input  logic     clr_dirty,
    output logic     hit,
    output logic     valid_out,
    output logic     dirty_out,
    output lc3b_tag  tag_out
);

    logic    valid_q [NUM_SETS];
    logic    dirty_q [NUM_SETS];
    lc3b_tag tag_q   [NUM_SETS];

    assign valid_out = valid_q[set];
    assign dirty_out = dirty_q[set];
    assign tag_out   = tag_q[set];
    assign hit       = valid_q[set] && (tag_q[set] == tag_in);

    // A fill installs a clean line, so it overrides any dirty update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else if (load_tag) begin
            valid_q[set] <= 1'b1;
            dirty_q[set] <= 1'b0;
            tag_q[set]   <= tag_in;
        end else if (set_dirty) begin
            dirty_q[set] <= 1'b1;
        end else if (clr_dirty) begin
            dirty_q[set] <= 1'b0;
        end
    end

endmodule

// File: rtl/cache_control.sv
// Direct-mapped write-back L1 controller: hit/miss decision, data-array
// strobes, and writeback/fill sequencing toward physical memory.
module cache_control
    import lc3b_types::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  lc3b_word        mem_address,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic            mem_resp,
    output lc3b_3bit        set,
    output lc3b_3bit        offset,
    output logic            load_data,
    output logic            write,
    output lc3b_word        pmem_address,
    output logic            pmem_read,
    output logic            pmem_write,
    input  logic            pmem_resp,
    output lc3b_cache_state state_dbg
);

    // Handshakes: the CPU holds mem_address and mem_read/mem_write stable until
    // a cycle with mem_resp=1; that cycle completes the request. Likewise
    // pmem_read/pmem_write stay high until a cycle with pmem_resp=1, which
    // completes the line transfer; pmem_resp in any other state is ignored.

    lc3b_cache_state state, next_state;
    lc3b_tag         tag_out;
    logic            hit, valid_out, dirty_out;
    logic            load_tag, set_dirty, clr_dirty;
    logic            req;

    assign set       = mem_address[6:4];
    assign offset    = mem_address[3:1];
    assign req       = mem_read || mem_write;
    assign state_dbg = state;

    cache_tag_array u_tags (
        .clk       (clk),
        .reset_n   (reset_n),
        .set       (set),
        .tag_in    (mem_address[15:7]),
        .load_tag  (load_tag),
        .set_dirty (set_dirty),
        .clr_dirty (clr_dirty),
        .hit       (hit),
        .valid_out (valid_out),
        .dirty_out (dirty_out),
        .tag_out   (tag_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state   = state;
        mem_resp     = 1'b0;
        load_data    = 1'b0;
        write        = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        load_tag     = 1'b0;
        set_dirty    = 1'b0;
        clr_dirty    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous read+write is served as a write.
                        mem_resp  = 1'b1;
                        write     = mem_write;
                        set_dirty = mem_write;
                    end else if (valid_out && dirty_out) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_out, set, 4'b0000};
                if (pmem_resp) begin
                    clr_dirty  = 1'b1;
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[15:4], 4'b0000};
                if (pmem_resp) begin
                    load_data  = 1'b1;
                    load_tag   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
